rhd_headstage_emulator_array: RTL and testbench

- Parametrised emulator for an array of Intan RHD2000-series headstage chips.
- Presents one shared SPI slave interface (MOSI, SCLK, CS) and drives N_PROBES*CHIPS_PER_PROBE MISO lines.
- Decodes real RHD commands (CONVERT, CALIBRATE, WRITE, READ) and keeps a shared register file.
- Returns each result with the genuine RHD two-frame pipeline latency. Per-chip seeded sample generators keep the data streams distinct.
- Serves as the bench/bring-up stand-in for the physical headstages behind the headstage SPI master.

---
 rtl/rhd_emu_pkg.sv | 45 ++++
 rtl/rhd_headstage_emulator_array_if.sv | 14 +
 rtl/rhd_chip_datapath.sv | 84 ++++++++
 rtl/rhd_headstage_emulator_array.sv | 158 +++++++++++++++
 tb/tb_rhd_headstage_emulator_array.sv | 198 +++++++++++++++++++
 5 files changed

// File: rtl/rhd_emu_pkg.sv
// Shared constants and helpers for the RHD2000 headstage array emulator:
// opcodes, LFSR mask, ROM register map and per-chip seed derivation.
package rhd_emu_pkg;

  typedef enum logic [1:0] {
    OP_CONVERT   = 2'b00,
    OP_CALIBRATE = 2'b01,
    OP_WRITE     = 2'b10,
    OP_READ      = 2'b11
  } rhd_op_e;

  localparam int          REG_COUNT      = 22;
  localparam logic [5:0]  REG_ADDR_LIMIT = 6'd22;
  localparam logic [15:0] LFSR_MASK      = 16'hB400;
  localparam logic [15:0] ZERO_SEED_SUB  = 16'hACE1;
  localparam logic [5:0]  ADDR_INTAN_I   = 6'd40;
  localparam logic [5:0]  ADDR_INTAN_N0  = 6'd41;
  localparam logic [5:0]  ADDR_INTAN_T   = 6'd42;
  localparam logic [5:0]  ADDR_INTAN_A   = 6'd43;
  localparam logic [5:0]  ADDR_INTAN_N1  = 6'd44;
  localparam logic [5:0]  ADDR_CHIP_ID   = 6'd63;

  function automatic logic [7:0] rom_byte(input logic [5:0] addr);
    case (addr)
      ADDR_INTAN_I:  return 8'h49;
      ADDR_INTAN_N0: return 8'h4E;
      ADDR_INTAN_T:  return 8'h54;
      ADDR_INTAN_A:  return 8'h41;
      ADDR_INTAN_N1: return 8'h4E;
      default:       return 8'h00;
    endcase
  endfunction

  // An all-zero Galois LFSR would lock up, so seed 0 is substituted.
  function automatic logic [15:0] chip_seed(input int seed_base, input int seed_stride, input int idx);
    logic [31:0] raw;
    raw = 32'(seed_base + idx * seed_stride);
    return (raw[15:0] == 16'h0000) ? ZERO_SEED_SUB : raw[15:0];
  endfunction

  function automatic logic [15:0] lfsr_next(input logic [15:0] lfsr);
    return lfsr[0] ? ((lfsr >> 1) ^ LFSR_MASK) : (lfsr >> 1);
  endfunction

endpackage

// File: rtl/rhd_headstage_emulator_array_if.sv
// SPI bundle between the headstage SPI master and the emulated chip array.
interface rhd_headstage_emulator_array_if #(
  parameter int N_MISO = 32
);
  logic              MOSI;
  logic              SCLK;
  logic              CS;
  logic [N_MISO-1:0] MISO;
  logic              frame_done;
  logic [7:0]        frame_err_cnt;

  modport master (output MOSI, SCLK, CS, input MISO, frame_done, frame_err_cnt);
  modport slave  (input MOSI, SCLK, CS, output MISO, frame_done, frame_err_cnt);
endinterface

// File: rtl/rhd_chip_datapath.sv
// One emulated chip: sample generator, two-stage result pipeline, MISO shifter.
// RHD_RAMP_TEST_EN swaps the LFSR generator for a 4-bit ramp counter.
module rhd_chip_datapath
  import rhd_emu_pkg::*;
#(
`ifdef RHD_RAMP_TEST_EN
  parameter logic [5:0]  CHIP_TAG = 6'd0
`else
  parameter logic [15:0] SEED = 16'hACE1
`endif
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_frame,
  input  logic        load,
  input  logic        shift,
  input  logic        exec,
  input  logic        is_convert,
  input  logic        conv_ok,
  input  logic [5:0]  ch,
  input  logic [15:0] common_word,
  output logic        miso
);

  logic [15:0] sample;
  logic [15:0] result;
  logic [15:0] stage1_r;
  logic [15:0] stage2_r;
  logic [15:0] shifter_r;
  logic        miso_r;
  logic        advance;

  assign advance = exec & conv_ok;

`ifdef RHD_RAMP_TEST_EN
  logic [3:0] ramp_r;
  assign sample = {CHIP_TAG, ch, ramp_r};

  // Ramp counter steps once per accepted in-range CONVERT
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       ramp_r <= 4'd0;
    else if (advance) ramp_r <= ramp_r + 4'd1;
    else              ramp_r <= ramp_r;
  end
`else
  logic [15:0] lfsr_r;
  assign sample = lfsr_r + {10'd0, ch};

  // LFSR steps once per accepted in-range CONVERT
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       lfsr_r <= SEED;
    else if (advance) lfsr_r <= lfsr_next(lfsr_r);
    else              lfsr_r <= lfsr_r;
  end
`endif

  always_comb begin
    result = common_word;
    if (is_convert) result = conv_ok ? sample : 16'h0000;
    else            result = common_word;
  end

  // Result pipeline and output shifter; stage2 is what the next frame sends
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage1_r  <= 16'h0000;
      stage2_r  <= 16'h0000;
      shifter_r <= 16'h0000;
      miso_r    <= 1'b0;
    end else begin
      if (exec) begin
        stage2_r <= stage1_r;
        stage1_r <= result;
      end
      if (load)       shifter_r <= stage2_r;
      else if (shift) shifter_r <= {shifter_r[14:0], 1'b0};
      else            shifter_r <= shifter_r;
      miso_r <= in_frame & shifter_r[15];
    end
  end

  assign miso = miso_r;

endmodule

// File: rtl/rhd_headstage_emulator_array.sv
// RHD2000 headstage array emulator: SPI synchronisers, frame decoder, shared
// register file and one rhd_chip_datapath per MISO line (RHD_RAMP_TEST_EN optional).
module rhd_headstage_emulator_array
  import rhd_emu_pkg::*;
#(
  parameter int N_PROBES        = 16,
  parameter int CHIPS_PER_PROBE = 2,
  parameter int N_CHANNELS      = 32,
  parameter int SEED_BASE       = 0,
  parameter int SEED_STRIDE     = 64,
  parameter int CHIP_ID         = 1
) (
  input logic clk,
  input logic rst_n,
  rhd_headstage_emulator_array_if.slave spi
);

  localparam int         N_CHIPS      = N_PROBES * CHIPS_PER_PROBE;
  localparam logic [6:0] CH_LIMIT     = 7'(N_CHANNELS);
  localparam logic [7:0] CHIP_ID_BYTE = 8'(CHIP_ID);

  logic [2:0]  sclk_sync;
  logic [2:0]  cs_sync;
  logic [1:0]  mosi_sync;
  logic        sclk_rise, sclk_fall, cs_fall, cs_rise;
  logic        in_frame_r;
  logic [4:0]  bit_cnt_r, cnt_next;
  logic [15:0] cmd_r, cmd_next;
  logic        frame_end, frame_ok, frame_bad;
  rhd_op_e     op;
  logic [5:0]  addr;
  logic [7:0]  wdata;
  logic        is_convert, conv_ok;
  logic [15:0] read_word, common_word;
  logic [7:0]  reg_file [REG_COUNT];
  logic        frame_done_r;
  logic [7:0]  err_cnt_r;
  logic [N_CHIPS-1:0] miso_vec;

  // CS history resets low so a frame already open at reset release never starts
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_sync <= 3'b000;
      cs_sync   <= 3'b000;
      mosi_sync <= 2'b00;
    end else begin
      sclk_sync <= {sclk_sync[1:0], spi.SCLK};
      cs_sync   <= {cs_sync[1:0], spi.CS};
      mosi_sync <= {mosi_sync[0], spi.MOSI};
    end
  end

  assign sclk_rise = sclk_sync[1] & ~sclk_sync[2];
  assign sclk_fall = ~sclk_sync[1] & sclk_sync[2];
  assign cs_fall   = ~cs_sync[1] & cs_sync[2];
  assign cs_rise   = cs_sync[1] & ~cs_sync[2];

  // SCLK edge folded in before the CS-rise evaluation so a coincident edge counts
  always_comb begin
    cmd_next = cmd_r;
    cnt_next = bit_cnt_r;
    if (in_frame_r && sclk_rise) begin
      cmd_next = {cmd_r[14:0], mosi_sync[1]};
      cnt_next = (bit_cnt_r == 5'd31) ? bit_cnt_r : bit_cnt_r + 5'd1;
    end else begin
      cmd_next = cmd_r;
      cnt_next = bit_cnt_r;
    end
  end

  assign frame_end = in_frame_r & cs_rise;
  assign frame_ok  = frame_end & (cnt_next == 5'd16);
  assign frame_bad = frame_end & (cnt_next != 5'd16);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_frame_r <= 1'b0;
      bit_cnt_r  <= 5'd0;
      cmd_r      <= 16'h0000;
    end else if (cs_fall) begin
      in_frame_r <= 1'b1;
      bit_cnt_r  <= 5'd0;
      cmd_r      <= 16'h0000;
    end else if (frame_end) begin
      in_frame_r <= 1'b0;
      bit_cnt_r  <= 5'd0;
      cmd_r      <= cmd_next;
    end else begin
      bit_cnt_r  <= cnt_next;
      cmd_r      <= cmd_next;
    end
  end

  always_comb begin
    op         = rhd_op_e'(cmd_next[15:14]);
    addr       = cmd_next[13:8];
    wdata      = cmd_next[7:0];
    is_convert = (op == OP_CONVERT);
    conv_ok    = is_convert && ({1'b0, addr} < CH_LIMIT);
    read_word  = 16'h0000;
    if (addr < REG_ADDR_LIMIT)      read_word = {8'h00, reg_file[addr[4:0]]};
    else if (addr == ADDR_CHIP_ID)  read_word = {8'h00, CHIP_ID_BYTE};
    else                            read_word = {8'h00, rom_byte(addr)};
    case (op)
      OP_CALIBRATE: common_word = 16'h0000;
      OP_WRITE:     common_word = {8'hFF, wdata};
      OP_READ:      common_word = read_word;
      default:      common_word = 16'h0000;
    endcase
  end

  // Shared register file: every chip sees the same MOSI, so one copy suffices
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < REG_COUNT; r++) reg_file[r] <= 8'h00;
    end else if (frame_ok && (op == OP_WRITE) && (addr < REG_ADDR_LIMIT)) begin
      reg_file[addr[4:0]] <= wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_done_r <= 1'b0;
      err_cnt_r    <= 8'd0;
    end else begin
      frame_done_r <= frame_ok;
      if (frame_bad && (err_cnt_r != 8'hFF)) err_cnt_r <= err_cnt_r + 8'd1;
      else                                   err_cnt_r <= err_cnt_r;
    end
  end

  for (genvar i = 0; i < N_CHIPS; i++) begin : g_chip
    rhd_chip_datapath #(
`ifdef RHD_RAMP_TEST_EN
      .CHIP_TAG(6'(i))
`else
      .SEED(chip_seed(SEED_BASE, SEED_STRIDE, i))
`endif
    ) u_dp (
      .clk         (clk),
      .rst_n       (rst_n),
      .in_frame    (in_frame_r),
      .load        (cs_fall),
      .shift       (in_frame_r & sclk_fall),
      .exec        (frame_ok),
      .is_convert  (is_convert),
      .conv_ok     (conv_ok),
      .ch          (addr),
      .common_word (common_word),
      .miso        (miso_vec[i])
    );
  end

  assign spi.MISO          = miso_vec;
  assign spi.frame_done    = frame_done_r;
  assign spi.frame_err_cnt = err_cnt_r;

endmodule

// File: tb/tb_rhd_headstage_emulator_array.sv
// Directed table-driven bench for rhd_headstage_emulator_array (default and RHD_RAMP_TEST_EN builds).
module tb_rhd_headstage_emulator_array;

  localparam int NP = 16;
  localparam int CP = 2;
  localparam int NC = NP * CP;
  localparam int H  = 8;

  typedef struct {
    logic [15:0] cmd;
    int          nclk;
    bit          all;
    logic [15:0] e0;
    logic [15:0] e1;
    int          done;
    int          err;
  } vec_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int checks   = 0;
  int failures = 0;
  int done_seen;
  logic [15:0] got [NC];
  vec_t tbl [21];
  vec_t rtb [7];

  always #5 clk = ~clk;

  rhd_headstage_emulator_array_if #(.N_MISO(NC)) spi ();

  rhd_headstage_emulator_array #(
    .N_PROBES(NP), .CHIPS_PER_PROBE(CP), .N_CHANNELS(32),
    .SEED_BASE(0), .SEED_STRIDE(64), .CHIP_ID(1)
  ) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .spi   (spi)
  );

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check16(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%04h expected 0x%04h", name, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [15:0] cmd, input int nclk, input bit all,
                              input logic [15:0] e0, input logic [15:0] e1,
                              input int done, input int err);
    vec_t v;
    v.cmd = cmd; v.nclk = nclk; v.all = all; v.e0 = e0; v.e1 = e1; v.done = done; v.err = err;
    return v;
  endfunction

  task automatic sclk_pulse();
    wait_clk(H);
    spi.SCLK = 1'b1;
    wait_clk(H);
    spi.SCLK = 1'b0;
  endtask

  // One SPI frame; MISO bits captured just before each rising SCLK edge
  task automatic spi_frame(input logic [15:0] cmd, input int nclk);
    for (int c = 0; c < NC; c++) got[c] = 16'h0000;
    spi.CS = 1'b0;
    for (int b = 0; b < nclk; b++) begin
      spi.MOSI = (b < 16) ? cmd[15-b] : 1'b0;
      wait_clk(H);
      if (b < 16) for (int c = 0; c < NC; c++) got[c][15-b] = spi.MISO[c];
      spi.SCLK = 1'b1;
      wait_clk(H);
      spi.SCLK = 1'b0;
    end
    wait_clk(H);
    spi.CS   = 1'b1;
    spi.MOSI = 1'b0;
    done_seen = 0;
    for (int k = 0; k < 12; k++) begin
      wait_clk(1);
      if (spi.frame_done) done_seen++;
    end
    wait_clk(H);
  endtask

  task automatic apply(input vec_t v, input string tag);
    spi_frame(v.cmd, v.nclk);
    if (v.nclk == 16) begin
      if (v.all) begin
        for (int c = 0; c < NC; c++) check16($sformatf("%s miso[%0d]", tag, c), got[c], v.e0);
      end else begin
        check16($sformatf("%s miso[0]", tag), got[0], v.e0);
        check16($sformatf("%s miso[1]", tag), got[1], v.e1);
      end
    end
    check_int($sformatf("%s frame_done", tag), done_seen, v.done);
    check_int($sformatf("%s frame_err_cnt", tag), int'(spi.frame_err_cnt), v.err);
  endtask

  initial begin
    spi.CS = 1'b1; spi.SCLK = 1'b0; spi.MOSI = 1'b0;
    wait_clk(5);
    check16("reset miso[0]", {15'd0, spi.MISO[0]}, 16'h0000);
    check_int("reset frame_done", int'(spi.frame_done), 0);
    check_int("reset frame_err_cnt", int'(spi.frame_err_cnt), 0);
    rst_n = 1'b1;
    wait_clk(5);

`ifdef RHD_RAMP_TEST_EN
    for (int k = 0; k < 19; k++) begin
      spi_frame((k < 17) ? 16'h0200 : 16'h4000, 16);
      if (k >= 2) check16($sformatf("ramp frame%0d chip5", k), got[5], 16'h1420 + 16'((k - 2) % 16));
    end
`else
    tbl[0]  = mk(16'hE800, 16, 1'b1, 16'h0000, 16'h0000, 1, 0);
    tbl[1]  = mk(16'hE900, 16, 1'b1, 16'h0000, 16'h0000, 1, 0);
    tbl[2]  = mk(16'hEA00, 16, 1'b1, 16'h0049, 16'h0000, 1, 0);
    tbl[3]  = mk(16'hEB00, 16, 1'b1, 16'h004E, 16'h0000, 1, 0);
    tbl[4]  = mk(16'hEC00, 16, 1'b1, 16'h0054, 16'h0000, 1, 0);
    tbl[5]  = mk(16'hFF00, 16, 1'b1, 16'h0041, 16'h0000, 1, 0);
    tbl[6]  = mk(16'h0000, 16, 1'b1, 16'h004E, 16'h0000, 1, 0);
    tbl[7]  = mk(16'h0000, 16, 1'b1, 16'h0001, 16'h0000, 1, 0);
    tbl[8]  = mk(16'h85A5, 16, 1'b0, 16'hACE1, 16'h0040, 1, 0);
    tbl[9]  = mk(16'h2800, 16, 1'b0, 16'hE270, 16'h0020, 1, 0);
    tbl[10] = mk(16'h0000, 16, 1'b1, 16'hFFA5, 16'h0000, 1, 0);
    tbl[11] = mk(16'hC500, 16, 1'b1, 16'h0000, 16'h0000, 1, 0);
    tbl[12] = mk(16'h0300, 16, 1'b0, 16'h7138, 16'h0010, 1, 0);
    tbl[13] = mk(16'h0300, 16, 1'b1, 16'h00A5, 16'h0000, 1, 0);
    tbl[14] = mk(16'h4000, 12, 1'b0, 16'h0000, 16'h0000, 0, 1);
    tbl[15] = mk(16'h4000, 16, 1'b0, 16'h389F, 16'h000B, 1, 1);
    tbl[16] = mk(16'hFF00, 16, 1'b0, 16'h1C51, 16'h0007, 1, 1);
    tbl[17] = mk(16'hC500, 16, 1'b1, 16'h0000, 16'h0000, 1, 1);
    tbl[18] = mk(16'h8712, 16, 1'b1, 16'h0001, 16'h0000, 1, 1);
    tbl[19] = mk(16'h4000, 17, 1'b0, 16'h0000, 16'h0000, 0, 2);
    tbl[20] = mk(16'hFF00, 16, 1'b1, 16'h00A5, 16'h0000, 1, 2);
    for (int i = 0; i < 21; i++) apply(tbl[i], $sformatf("vec%0d", i));

    // Reset after the 8th rising SCLK edge; pipeline holds 0xFFxx so MISO is high here
    spi.CS = 1'b0;
    for (int b = 0; b < 7; b++) begin
      spi.MOSI = 1'b1;
      sclk_pulse();
    end
    wait_clk(H);
    spi.SCLK = 1'b1;
    wait_clk(2);
    rst_n = 1'b0;
    #1;
    for (int c = 0; c < NC; c++) check16($sformatf("midreset miso[%0d]", c), {15'd0, spi.MISO[c]}, 16'h0000);
    check_int("midreset frame_err_cnt", int'(spi.frame_err_cnt), 0);
    wait_clk(4);
    spi.SCLK = 1'b0;
    rst_n = 1'b1;
    wait_clk(4);
    for (int b = 0; b < 4; b++) sclk_pulse();
    wait_clk(H);
    spi.CS = 1'b1;
    spi.MOSI = 1'b0;
    done_seen = 0;
    for (int k = 0; k < 12; k++) begin
      wait_clk(1);
      if (spi.frame_done) done_seen++;
    end
    check_int("stale frame frame_done", done_seen, 0);
    check_int("stale frame frame_err_cnt", int'(spi.frame_err_cnt), 0);
    wait_clk(H);

    rtb[0] = mk(16'h0300, 16, 1'b1, 16'h0000, 16'h0000, 1, 0);
    rtb[1] = mk(16'h0300, 16, 1'b1, 16'h0000, 16'h0000, 1, 0);
    rtb[2] = mk(16'h0300, 16, 1'b0, 16'hACE4, 16'h0043, 1, 0);
    rtb[3] = mk(16'h4000, 16, 1'b0, 16'hE273, 16'h0023, 1, 0);
    rtb[4] = mk(16'hC700, 16, 1'b0, 16'h713B, 16'h0013, 1, 0);
    rtb[5] = mk(16'h4000, 16, 1'b1, 16'h0000, 16'h0000, 1, 0);
    rtb[6] = mk(16'h4000, 16, 1'b1, 16'h0000, 16'h0000, 1, 0);
    for (int i = 0; i < 7; i++) begin
      apply(rtb[i], $sformatf("post_reset%0d", i));
      if (i == 2) check16("post_reset2 miso[31]", got[31], 16'h07C3);
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
